noc_input_buffer: RTL

- Per-port input stage that sits directly upstream of the XY/odd-even route-compute stage.
- Buffers incoming flits in a first-word-fall-through FIFO and tracks wormhole packet state.
- Extracts dest_x/dest_y from the head flit and holds them for the whole packet, so the route stage sees a stable destination with every flit.
- Returns one credit upstream per flit drained.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/noc_fifo.sv | 58 +++++
 rtl/noc_input_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC types: flit encodings, port directions, header field offsets
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    localparam logic [2:0] EAST  = 3'd0;
    localparam logic [2:0] WEST  = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;

    // dest_x starts at bit 0; dest_y sits directly above dest_x.
    localparam int DEST_X_LSB = 0;

    function automatic int dest_y_lsb(input int x_bits);
        return DEST_X_LSB + x_bits;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - first-word-fall-through FIFO with full/empty flags
//
// Ports: clk, rst (async active-high), push/wdata write side, pop/rdata read
// side (rdata shows the oldest entry whenever empty=0), full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
module noc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - NoC input port buffer with wormhole tracking and credit return
//
// Ports: clk, rst (async active-high); in_valid/in_type/in_data input link;
// credit_out one pulse per flit removed; out_valid/out_ready/out_data/out_type
// plus out_dest_x/out_dest_y toward the route stage; err sticky error.
// Optional macro NOC_IBUF_STATS_EN adds pkt_count/flit_count saturating counters.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int X_SIZE = 4,
    parameter int Y_SIZE = 4,
    parameter int X_BITS = $clog2(X_SIZE),
    parameter int Y_BITS = $clog2(Y_SIZE),
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_type,
    input  logic [WIDTH-1:0]  in_data,
    output logic              credit_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        out_type,
    output logic [X_BITS-1:0] out_dest_x,
    output logic [Y_BITS-1:0] out_dest_y,
`ifdef NOC_IBUF_STATS_EN
    output logic [15:0]       pkt_count,
    output logic [15:0]       flit_count,
`endif
    output logic              err
);

    localparam int Y_LSB = dest_y_lsb(X_BITS);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [X_BITS-1:0] dest_x_q, dest_x_d;
    logic [Y_BITS-1:0] dest_y_q, dest_y_d;
    logic              credit_q, credit_d;
    logic              err_q, err_d;

    logic [WIDTH+1:0]  head_flit;
    logic              fifo_full, fifo_empty;
    flit_type_e        head_type;
    logic [X_BITS-1:0] head_dest_x;
    logic [Y_BITS-1:0] head_dest_y;
    logic              is_start, drop, accept, pop, overflow;

    noc_fifo #(
        .WIDTH (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({in_type, in_data}),
        .pop   (pop),
        .rdata (head_flit),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_type   = flit_type_e'(head_flit[WIDTH+1:WIDTH]);
    assign head_dest_x = head_flit[DEST_X_LSB +: X_BITS];
    assign head_dest_y = head_flit[Y_LSB +: Y_BITS];

    always_comb begin
        is_start = (head_type == FLIT_HEAD) || (head_type == FLIT_HEADTAIL);
        // A start flit is legal only between packets, a continuation only inside one.
        out_valid = !fifo_empty && ((state_q == ST_IDLE) ? is_start : !is_start);
        drop      = !fifo_empty && !out_valid;
        accept    = out_valid && out_ready;
        pop       = accept || drop;
        overflow  = in_valid && fifo_full && !pop;

        state_d  = state_q;
        dest_x_d = dest_x_q;
        dest_y_d = dest_y_q;
        credit_d = pop;
        err_d    = err_q || drop || overflow;

        if (accept) begin
            if (state_q == ST_IDLE) begin
                // HEADTAIL also latches so the dest outputs hold after it leaves.
                dest_x_d = head_dest_x;
                dest_y_d = head_dest_y;
                if (head_type == FLIT_HEAD) begin
                    state_d = ST_ACTIVE;
                end
            end else if (head_type == FLIT_TAIL) begin
                state_d = ST_IDLE;
            end
        end

        // While a head is waiting in IDLE its own payload drives the dest lines.
        if (out_valid && (state_q == ST_IDLE)) begin
            out_dest_x = head_dest_x;
            out_dest_y = head_dest_y;
        end else begin
            out_dest_x = dest_x_q;
            out_dest_y = dest_y_q;
        end
    end

    assign out_data   = head_flit[WIDTH-1:0];
    assign out_type   = head_flit[WIDTH+1:WIDTH];
    assign credit_out = credit_q;
    assign err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dest_x_q <= '0;
            dest_y_q <= '0;
            credit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_x_q <= dest_x_d;
            dest_y_q <= dest_y_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

`ifdef NOC_IBUF_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] flit_count_q, flit_count_d;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        flit_count_d = flit_count_q;
        if (accept && is_start && (pkt_count_q != 16'hFFFF)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
        if (accept && (flit_count_q != 16'hFFFF)) begin
            flit_count_d = flit_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_q  <= '0;
            flit_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign flit_count = flit_count_q;
`endif

endmodule
